// File: rtl/pipe_reg_de_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_reg_de_pkg
// Brief   : Shared MIPS decode constants for the D/E, E/M and M/W pipeline
//           registers and the hazard unit: result-source encodings,
//           instruction field ranges, opcode/func values, link register.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_reg_de_pkg;

    // Result source of an instruction, as seen by the hazard unit
    typedef enum logic [1:0] {
        RES_NW  = 2'b00,   // writes no register
        RES_ALU = 2'b01,   // result produced by the ALU in E
        RES_DM  = 2'b10,   // result produced by data memory in M
        RES_PC  = 2'b11    // link value (PC+8)
    } res_e;

    // Instruction field ranges
    localparam int c_op_hi   = 31;
    localparam int c_op_lo   = 26;
    localparam int c_rs_hi   = 25;
    localparam int c_rs_lo   = 21;
    localparam int c_rt_hi   = 20;
    localparam int c_rt_lo   = 16;
    localparam int c_rd_hi   = 15;
    localparam int c_rd_lo   = 11;
    localparam int c_func_hi = 5;
    localparam int c_func_lo = 0;

    // Primary opcodes
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] c_func_jr   = 6'h08;
    localparam logic [5:0] c_func_jalr = 6'h09;
    localparam logic [5:0] c_func_movz = 6'h0A;
    localparam logic [5:0] c_func_addu = 6'h21;
    localparam logic [5:0] c_func_subu = 6'h23;

    // Register written by jal
    localparam logic [4:0] c_link_reg_default = 5'd31;

    // Contents of the D/E register
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [1:0]  res;
        logic        valid;
    } de_regs_t;

    // Bubble / reset image of the D/E register
    function automatic de_regs_t f_bubble(input logic [31:0] nop_ir);
        de_regs_t r;
        r    = '0;
        r.ir = nop_ir;
        return r;
    endfunction

endpackage : pipe_reg_de_pkg
`default_nettype wire

// File: rtl/pipe_reg_de_res_decode.sv
`default_nettype none
// ============================================================================
// Module  : pipe_reg_de_res_decode
// Brief   : Combinational classifier: instruction word -> result source and
//           destination register, with the zero-destination rule applied.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_reg_de_res_decode
    import pipe_reg_de_pkg::*;
#(
    parameter logic [4:0] LINK_REG = c_link_reg_default
) (
    input  logic [31:0] ir_i,
    output logic [1:0]  res_o,
    output logic [4:0]  a3_o
);

    logic [5:0] w_op;
    logic [5:0] w_func;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [1:0] w_res;
    logic [4:0] w_a3;
    logic       w_unused_fields;

    assign w_op   = ir_i[c_op_hi:c_op_lo];
    assign w_func = ir_i[c_func_hi:c_func_lo];
    assign w_rt   = ir_i[c_rt_hi:c_rt_lo];
    assign w_rd   = ir_i[c_rd_hi:c_rd_lo];

    // rs and shamt never name a destination
    assign w_unused_fields = ^{ir_i[c_rs_hi:c_rs_lo], ir_i[10:6]};

    // Classify by opcode/func; movz counts as writing since its condition
    // is only resolved later in the pipe
    always_comb begin
        w_res = RES_NW;
        w_a3  = 5'd0;
        case (w_op)
            c_op_rtype: begin
                case (w_func)
                    c_func_addu, c_func_subu, c_func_movz: begin
                        w_res = RES_ALU;
                        w_a3  = w_rd;
                    end
                    c_func_jalr: begin
                        w_res = RES_PC;
                        w_a3  = w_rd;
                    end
                    default: ;
                endcase
            end
            c_op_ori, c_op_xori, c_op_lui: begin
                w_res = RES_ALU;
                w_a3  = w_rt;
            end
            c_op_lw: begin
                w_res = RES_DM;
                w_a3  = w_rt;
            end
            c_op_jal: begin
                w_res = RES_PC;
                w_a3  = LINK_REG;
            end
            default: ;
        endcase
    end

    // A write to $0 is no write at all
    assign res_o = (w_a3 == 5'd0) ? RES_NW : w_res;
    assign a3_o  = w_a3;

endmodule : pipe_reg_de_res_decode
`default_nettype wire

// File: rtl/pipe_reg_de.sv
`default_nettype none
// ============================================================================
// Module  : pipe_reg_de
// Brief   : Decode-to-Execute pipeline register. Captures D-stage operands,
//           classifies the instruction for the hazard unit, and turns a
//           stall into a bubble in E.
//           Optional macro PIPE_REG_DE_PERF_EN adds a bubble counter output.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_reg_de
    import pipe_reg_de_pkg::*;
#(
    parameter logic [31:0] NOP_IR   = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG = c_link_reg_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] IR_D,
    input  logic [31:0] PC8_D,
    input  logic [31:0] RS_D,
    input  logic [31:0] RT_D,
    input  logic [31:0] EXT_D,
    output logic [31:0] IR_E,
    output logic [31:0] PC8_E,
    output logic [31:0] RS_E,
    output logic [31:0] RT_E,
    output logic [31:0] EXT_E,
    output logic [4:0]  A1_E,
    output logic [4:0]  A2_E,
    output logic [4:0]  A3_E,
    output logic [1:0]  Res_E,
    output logic        valid_E
`ifdef PIPE_REG_DE_PERF_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    localparam de_regs_t c_bubble = f_bubble(NOP_IR);

    de_regs_t   de_d;
    de_regs_t   de_q;
    logic [1:0] w_res;
    logic [4:0] w_a3;

    pipe_reg_de_res_decode #(
        .LINK_REG (LINK_REG)
    ) u_res_decode (
        .ir_i  (IR_D),
        .res_o (w_res),
        .a3_o  (w_a3)
    );

    // Next state: a stall selects the bubble image, otherwise load from D
    always_comb begin
        de_d = c_bubble;
        if (!stall) begin
            de_d.ir    = IR_D;
            de_d.pc8   = PC8_D;
            de_d.rs    = RS_D;
            de_d.rt    = RT_D;
            de_d.ext   = EXT_D;
            de_d.a1    = IR_D[c_rs_hi:c_rs_lo];
            de_d.a2    = IR_D[c_rt_hi:c_rt_lo];
            de_d.a3    = w_a3;
            de_d.res   = w_res;
            de_d.valid = 1'b1;
        end
    end

    // Pipeline register with asynchronous clear to the bubble image
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q <= c_bubble;
        end else begin
            de_q <= de_d;
        end
    end

    assign IR_E    = de_q.ir;
    assign PC8_E   = de_q.pc8;
    assign RS_E    = de_q.rs;
    assign RT_E    = de_q.rt;
    assign EXT_E   = de_q.ext;
    assign A1_E    = de_q.a1;
    assign A2_E    = de_q.a2;
    assign A3_E    = de_q.a3;
    assign Res_E   = de_q.res;
    assign valid_E = de_q.valid;

`ifdef PIPE_REG_DE_PERF_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    assign bubble_cnt_d = bubble_cnt_q + 32'd1;

    // Count stalled edges; wraps naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= 32'd0;
        end else if (stall) begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule : pipe_reg_de
`default_nettype wire

// File: tb/tb_pipe_reg_de.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_reg_de
// Brief   : Self-checking bench for pipe_reg_de: reference model at the
//           mnemonic level, per-cycle compare, and directed vectors with
//           literal expectations. Honours PIPE_REG_DE_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_reg_de;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] IR_D, PC8_D, RS_D, RT_D, EXT_D;
    logic [31:0] IR_E, PC8_E, RS_E, RT_E, EXT_E;
    logic [4:0]  A1_E, A2_E, A3_E;
    logic [1:0]  Res_E;
    logic        valid_E;
`ifdef PIPE_REG_DE_PERF_EN
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    pipe_reg_de dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .IR_D    (IR_D),
        .PC8_D   (PC8_D),
        .RS_D    (RS_D),
        .RT_D    (RT_D),
        .EXT_D   (EXT_D),
        .IR_E    (IR_E),
        .PC8_E   (PC8_E),
        .RS_E    (RS_E),
        .RT_E    (RT_E),
        .EXT_E   (EXT_E),
        .A1_E    (A1_E),
        .A2_E    (A2_E),
        .A3_E    (A3_E),
        .Res_E   (Res_E),
        .valid_E (valid_E)
`ifdef PIPE_REG_DE_PERF_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_ir, m_pc8, m_rs, m_rt, m_ext, m_cnt;
    logic [4:0]  m_a1, m_a2, m_a3;
    logic [1:0]  m_res;
    logic        m_valid;

    // Mnemonic-level table: what register does this instruction write, and from where
    function automatic void classify(input logic [31:0] ir, output logic [1:0] res, output logic [4:0] a3);
        logic [5:0] op;
        logic [5:0] fn;
        op  = ir[31:26];
        fn  = ir[5:0];
        res = 2'd0;
        a3  = 5'd0;
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h0A)) begin res = 2'd1; a3 = ir[15:11]; end
        if (op == 6'h00 && fn == 6'h09)                                  begin res = 2'd3; a3 = ir[15:11]; end
        if (op == 6'h0D || op == 6'h0E || op == 6'h0F)                   begin res = 2'd1; a3 = ir[20:16]; end
        if (op == 6'h23)                                                 begin res = 2'd2; a3 = ir[20:16]; end
        if (op == 6'h03)                                                 begin res = 2'd3; a3 = 5'd31;     end
        if (a3 == 5'd0) res = 2'd0;
    endfunction

    task automatic m_clear();
        m_ir = 32'h0; m_pc8 = 0; m_rs = 0; m_rt = 0; m_ext = 0;
        m_a1 = 0; m_a2 = 0; m_a3 = 0; m_res = 0; m_valid = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear();
            m_cnt = 0;
        end else if (stall) begin
            m_clear();
            m_cnt = m_cnt + 1;
        end else begin
            m_ir = IR_D; m_pc8 = PC8_D; m_rs = RS_D; m_rt = RT_D; m_ext = EXT_D;
            m_a1 = IR_D[25:21]; m_a2 = IR_D[20:16];
            classify(IR_D, m_res, m_a3);
            m_valid = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("IR_E",    IR_E,           m_ir);
            chk("PC8_E",   PC8_E,          m_pc8);
            chk("RS_E",    RS_E,           m_rs);
            chk("RT_E",    RT_E,           m_rt);
            chk("EXT_E",   EXT_E,          m_ext);
            chk("A1_E",    {27'd0, A1_E},  {27'd0, m_a1});
            chk("A2_E",    {27'd0, A2_E},  {27'd0, m_a2});
            chk("A3_E",    {27'd0, A3_E},  {27'd0, m_a3});
            chk("Res_E",   {30'd0, Res_E}, {30'd0, m_res});
            chk("valid_E", {31'd0, valid_E}, {31'd0, m_valid});
`ifdef PIPE_REG_DE_PERF_EN
            chk("bubble_cnt", bubble_cnt, m_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc8, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext, input logic st);
        IR_D = ir; PC8_D = pc8; RS_D = rs; RT_D = rt; EXT_D = ext; stall = st;
    endtask

    task automatic drive_rand();
        drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    // Classification sweep: instruction, expected Res, expected A3
    logic [31:0] sw_ir  [12] = '{32'h00221821, 32'h0C000010, 32'h00802809, 32'hAC220000,
                                 32'h10220004, 32'h34200001, 32'h38270005, 32'h3C061234,
                                 32'h00A6200A, 32'h03E00008, 32'h00000000, 32'h00220021};
    logic [1:0]  sw_res [12] = '{2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [4:0]  sw_a3  [12] = '{5'd3, 5'd31, 5'd5, 5'd0, 5'd0, 5'd0, 5'd7, 5'd6, 5'd4, 5'd0, 5'd0, 5'd0};

    initial begin
        reset = 1'b1;
        drive_rand();
        #1 reset = 1'b0;
        #1 chk_on = 1'b1;

        // Reset held with random inputs and a running clock
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_rand();
        end
        @(negedge clk);
        chk("rst IR_E",    IR_E,             32'h0);
        chk("rst valid_E", {31'd0, valid_E}, 32'd0);
        chk("rst RS_E",    RS_E,             32'h0);

        // First load after release: lw $8,4($9)
        reset = 1'b1;
        drive(32'h8D280004, 32'h0, 32'h0, 32'h0, 32'h4, 1'b0);
        @(negedge clk);
        chk("lw Res_E",   {30'd0, Res_E},   32'd2);
        chk("lw A3_E",    {27'd0, A3_E},    32'd8);
        chk("lw A1_E",    {27'd0, A1_E},    32'd9);
        chk("lw A2_E",    {27'd0, A2_E},    32'd8);
        chk("lw valid_E", {31'd0, valid_E}, 32'd1);

        // Classification sweep
        for (int i = 0; i < 12; i++) begin
            drive(sw_ir[i], 32'h100 + 32'(i), 32'(i), 32'(i) * 3, 32'(i) * 7, 1'b0);
            @(negedge clk);
            chk($sformatf("sweep%0d Res_E", i), {30'd0, Res_E}, {30'd0, sw_res[i]});
            chk($sformatf("sweep%0d A3_E", i),  {27'd0, A3_E},  {27'd0, sw_a3[i]});
        end

        // Passthrough, plus unchanged-before-edge
        drive(32'h00221821, 32'h00001111, 32'h0, 32'h00002222, 32'h00003333, 1'b0);
        @(negedge clk);
        drive(32'h00221821, 32'h00003008, 32'h0, 32'hDEADBEEF, 32'hFFFF8000, 1'b0);
        #1;
        chk("pre PC8_E", PC8_E, 32'h00001111);
        chk("pre RT_E",  RT_E,  32'h00002222);
        chk("pre EXT_E", EXT_E, 32'h00003333);
        @(negedge clk);
        chk("pass PC8_E", PC8_E, 32'h00003008);
        chk("pass RT_E",  RT_E,  32'hDEADBEEF);
        chk("pass EXT_E", EXT_E, 32'hFFFF8000);

        // Two stalled edges then release: addu re-enters
        drive(32'h00221821, 32'h0, 32'h00001234, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall IR_E",    IR_E,             32'h0);
            chk("stall RS_E",    RS_E,             32'h0);
            chk("stall Res_E",   {30'd0, Res_E},   32'd0);
            chk("stall valid_E", {31'd0, valid_E}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall IR_E",  IR_E,           32'h00221821);
        chk("unstall RS_E",  RS_E,           32'h00001234);
        chk("unstall Res_E", {30'd0, Res_E}, 32'd1);
        chk("unstall A3_E",  {27'd0, A3_E},  32'd3);

        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        chk("async valid_E", {31'd0, valid_E}, 32'd0);
        chk("async IR_E",    IR_E,             32'h0);
        chk("async RS_E",    RS_E,             32'h0);
        chk("async A3_E",    {27'd0, A3_E},    32'd0);
        @(negedge clk);
        reset = 1'b1;

`ifdef PIPE_REG_DE_PERF_EN
        // 3 stalls, 2 clean, 1 stall
        for (int i = 0; i < 6; i++) begin
            drive(32'h00221821, 32'h0, 32'h0, 32'h0, 32'h0, (i == 3 || i == 4) ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        chk("perf count", bubble_cnt, 32'd4);
        // Wrap from all-ones
        #2;
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        stall = 1'b1;
        @(negedge clk);
        chk("perf wrap", bubble_cnt, 32'd0);
        stall = 1'b0;
`endif

        // A few random cycles covered by the model
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            @(negedge clk);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_reg_de
`default_nettype wire
